nts_cookie_extractor: RTL and testbench

- Sits directly upstream of nts_cookie_handler.
- Consumes a received NTS Cookie extension field (832 bits) delivered as 64-bit words from the RX parser.
- Validates the header, publishes the master-key ID, and streams nonce, tag, C2S and S2C as 32-bit indexed words with one-hot field strobes, matching the handler's cookie write port.
- Then pulses the unwrap command.

---
 rtl/nts_cookie_extractor_if.sv | 11 +
 rtl/nts_cookie_extractor.sv | 169 ++++++++++++++++
 tb/tb_nts_cookie_extractor.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_cookie_extractor_if.sv
// 64-bit extension word stream from the RX parser into the cookie extractor.
interface nts_cookie_extractor_if;
    logic        valid;
    logic        first;
    logic        last;
    logic [63:0] data;
    logic        ready;

    modport master (output valid, output first, output last, output data, input ready);
    modport slave  (input valid, input first, input last, input data, output ready);
endinterface

// File: rtl/nts_cookie_extractor.sv
// Parses a received NTS Cookie extension (header + 12 body words) and streams
// nonce/tag/C2S/S2C as indexed 32-bit words into the cookie handler, then starts unwrap.
module nts_cookie_extractor #(
    parameter logic [15:0] EXT_TAG = 16'h0204,
    parameter logic [15:0] EXT_LEN = 16'h0068
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,
    nts_cookie_extractor_if.slave ext,
    input  logic                  i_handler_busy,
    output logic [31:0]           o_key_id,
    output logic                  o_key_id_valid,
    output logic                  o_cookie_nonce,
    output logic                  o_cookie_tag,
    output logic                  o_cookie_c2s,
    output logic                  o_cookie_s2c,
    output logic [3:0]            o_cookie_word,
    output logic [31:0]           o_cookie_data,
    output logic                  o_op_unwrap,
    output logic                  o_error
);
    typedef enum logic [2:0] {IDLE, BODY_HI, BODY_LO, UNWRAP, DRAIN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        last_q, last_nx;
    logic [31:0] word_lo, word_lo_nx;
    logic [31:0] key_id_nx, data_nx;
    logic [3:0]  field_nx, word_nx;
    logic        key_vld_nx, unwrap_nx, error_nx;
    logic        ready, hdr_ok;

    // One-hot {nonce, tag, c2s, s2c} for body word n.
    function automatic logic [3:0] field_sel(input logic [3:0] n);
        if (n < 4'd2)      return 4'b1000;
        else if (n < 4'd4) return 4'b0100;
        else if (n < 4'd8) return 4'b0010;
        else               return 4'b0001;
    endfunction

    // Position of body word n within its field, counted in 64-bit pairs.
    function automatic logic [1:0] field_pair(input logic [3:0] n);
        return (n < 4'd4) ? {1'b0, n[0]} : n[1:0];
    endfunction

    assign hdr_ok    = (ext.data[63:48] == EXT_TAG) && (ext.data[47:32] == EXT_LEN);
    assign ext.ready = ready;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:           ready = !i_handler_busy;
            BODY_HI, DRAIN: ready = 1'b1;
            default:        ready = 1'b0;
        endcase
        ready = ready & i_areset_n;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        last_nx    = last_q;
        word_lo_nx = word_lo;
        key_id_nx  = o_key_id;
        key_vld_nx = 1'b0;
        field_nx   = 4'b0000;
        word_nx    = o_cookie_word;
        data_nx    = o_cookie_data;
        unwrap_nx  = 1'b0;
        error_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (ext.valid && ready && ext.first) begin
                    // A header that is also the last word cannot carry a body.
                    if (hdr_ok && !ext.last) begin
                        key_id_nx  = ext.data[31:0];
                        key_vld_nx = 1'b1;
                        cnt_nx     = 4'd0;
                        state_nx   = BODY_HI;
                    end else begin
                        error_nx = 1'b1;
                        state_nx = ext.last ? IDLE : DRAIN;
                    end
                end
            end
            BODY_HI: begin
                if (ext.valid) begin
                    if (ext.first) begin
                        error_nx = 1'b1;
                        state_nx = DRAIN;
                    end else begin
                        word_lo_nx = ext.data[31:0];
                        last_nx    = ext.last;
                        field_nx   = field_sel(cnt);
                        word_nx    = {1'b0, field_pair(cnt), 1'b0};
                        data_nx    = ext.data[63:32];
                        state_nx   = BODY_LO;
                    end
                end
            end
            BODY_LO: begin
                field_nx = field_sel(cnt);
                word_nx  = {1'b0, field_pair(cnt), 1'b1};
                data_nx  = word_lo;
                cnt_nx   = cnt + 4'd1;
                // Framing is judged once both halves of the word are out.
                if (cnt == 4'd11) begin
                    if (last_q) begin
                        state_nx = UNWRAP;
                    end else begin
                        error_nx = 1'b1;
                        state_nx = DRAIN;
                    end
                end else if (last_q) begin
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = BODY_HI;
                end
            end
            UNWRAP: begin
                if (!i_handler_busy) begin
                    unwrap_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
            DRAIN: begin
                if (ext.valid && ext.last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            last_q         <= 1'b0;
            o_key_id       <= 32'd0;
            o_key_id_valid <= 1'b0;
            o_cookie_nonce <= 1'b0;
            o_cookie_tag   <= 1'b0;
            o_cookie_c2s   <= 1'b0;
            o_cookie_s2c   <= 1'b0;
            o_cookie_word  <= 4'd0;
            o_cookie_data  <= 32'd0;
            o_op_unwrap    <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            last_q         <= last_nx;
            o_key_id       <= key_id_nx;
            o_key_id_valid <= key_vld_nx;
            o_cookie_nonce <= field_nx[3];
            o_cookie_tag   <= field_nx[2];
            o_cookie_c2s   <= field_nx[1];
            o_cookie_s2c   <= field_nx[0];
            o_cookie_word  <= word_nx;
            o_cookie_data  <= data_nx;
            o_op_unwrap    <= unwrap_nx;
            o_error        <= error_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        word_lo <= word_lo_nx;
    end
endmodule

// File: tb/tb_nts_cookie_extractor.sv
// Directed bench for nts_cookie_extractor: valid cookies, busy back-pressure,
// header and framing errors, and reset in the middle of a body.
module tb_nts_cookie_extractor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [31:0] key_id;
    logic        key_vld, c_nonce, c_tag, c_c2s, c_s2c;
    logic [3:0]  c_word;
    logic [31:0] c_data;
    logic        unwrap, err;
    logic [3:0]  fld_now;

    nts_cookie_extractor_if ifc();

    nts_cookie_extractor dut (
        .i_clk          (clk),
        .i_areset_n     (rst_n),
        .ext            (ifc),
        .i_handler_busy (busy),
        .o_key_id       (key_id),
        .o_key_id_valid (key_vld),
        .o_cookie_nonce (c_nonce),
        .o_cookie_tag   (c_tag),
        .o_cookie_c2s   (c_c2s),
        .o_cookie_s2c   (c_s2c),
        .o_cookie_word  (c_word),
        .o_cookie_data  (c_data),
        .o_op_unwrap    (unwrap),
        .o_error        (err)
    );

    always #5 clk = ~clk;
    assign fld_now = {c_nonce, c_tag, c_c2s, c_s2c};

    int checks = 0, errors = 0, stalls = 0, cyc = 0;
    int n_str = 0, n_unwrap = 0, n_err = 0, n_kv = 0, n_multi = 0;
    int unwrap_cyc = 0, kv_cyc = 0;
    logic [3:0]  s_fld [0:255];
    logic [3:0]  s_idx [0:255];
    logic [31:0] s_dat [0:255];
    int          s_cyc [0:255];
    logic [63:0] body  [0:11];

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (fld_now != 4'b0000 && n_str < 256) begin
            s_fld[n_str[7:0]] <= fld_now;
            s_idx[n_str[7:0]] <= c_word;
            s_dat[n_str[7:0]] <= c_data;
            s_cyc[n_str[7:0]] <= cyc;
            n_str <= n_str + 1;
            if ($countones(fld_now) != 1) n_multi <= n_multi + 1;
        end
        if (unwrap) begin
            n_unwrap   <= n_unwrap + 1;
            unwrap_cyc <= cyc;
        end
        if (err) n_err <= n_err + 1;
        if (key_vld) begin
            n_kv   <= n_kv + 1;
            kv_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [63:0] d, input logic f, input logic l);
        int n;
        n = 0;
        ifc.valid = 1'b1;
        ifc.data  = d;
        ifc.first = f;
        ifc.last  = l;
        @(negedge clk);
        while (!ifc.ready && n < 100) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!ifc.ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready got %b want 1 after %0d cycles", ifc.ready, n);
        end
        @(posedge clk); #1;
        ifc.valid = 1'b0;
        ifc.first = 1'b0;
        ifc.last  = 1'b0;
    endtask

    task automatic send_body(input int count, input int last_at);
        for (int i = 0; i < count; i++) send(body[i], 1'b0, (i == last_at));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; busy = 1'b0;
        ifc.valid = 1'b0; ifc.first = 1'b0; ifc.last = 1'b0; ifc.data = 64'd0;
        #2;
        checks++;
        if ({key_id, key_vld, fld_now, c_word, c_data, unwrap, err} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {key_id, key_vld, fld_now, c_word, c_data, unwrap, err});
        end
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ifc.ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ifc.ready); end
    endtask

    task automatic test_valid_cookie();
        int b0, u0, e0, k0, n, h, ep;
        logic [3:0]  ef, ei;
        logic [31:0] ed;
        b0 = n_str; u0 = n_unwrap; e0 = n_err; k0 = n_kv;
        send(64'h0204_0068_6c47f0d3, 1'b1, 1'b0);
        send_body(12, 11);
        settle();
        checks++;
        if (key_id !== 32'h6c47f0d3) begin errors++; $display("FAIL valid_key_id: got %h want 6c47f0d3", key_id); end
        checks++;
        if (n_kv - k0 !== 1) begin errors++; $display("FAIL valid_key_pulse: got %0d want 1", n_kv - k0); end
        checks++;
        if (n_str - b0 !== 24) begin errors++; $display("FAIL valid_strobe_count: got %0d want 24", n_str - b0); end
        for (int k = 0; k < 24; k++) begin
            n = k / 2; h = k % 2;
            if (n < 2)      begin ef = 4'b1000; ep = n;     end
            else if (n < 4) begin ef = 4'b0100; ep = n - 2; end
            else if (n < 8) begin ef = 4'b0010; ep = n - 4; end
            else            begin ef = 4'b0001; ep = n - 8; end
            ei = 4'(ep * 2 + h);
            ed = (h == 1) ? body[n][31:0] : body[n][63:32];
            checks++;
            if ({s_fld[8'(b0 + k)], s_idx[8'(b0 + k)], s_dat[8'(b0 + k)]} !== {ef, ei, ed}) begin
                errors++;
                $display("FAIL valid_strobe_%0d: got %b/%0d/%h want %b/%0d/%h", k,
                         s_fld[8'(b0 + k)], s_idx[8'(b0 + k)], s_dat[8'(b0 + k)], ef, ei, ed);
            end
        end
        checks++;
        if ({s_fld[8'(b0)], s_idx[8'(b0)], s_dat[8'(b0)]} !== {4'b1000, 4'd0, 32'hcd65766f}) begin
            errors++; $display("FAIL nonce_w0: got %h want cd65766f", s_dat[8'(b0)]); end
        checks++;
        if ({s_fld[8'(b0 + 3)], s_idx[8'(b0 + 3)], s_dat[8'(b0 + 3)]} !== {4'b1000, 4'd3, 32'hca60c5ec}) begin
            errors++; $display("FAIL nonce_w3: got %h want ca60c5ec", s_dat[8'(b0 + 3)]); end
        checks++;
        if ({s_fld[8'(b0 + 4)], s_idx[8'(b0 + 4)], s_dat[8'(b0 + 4)]} !== {4'b0100, 4'd0, 32'ha507af99}) begin
            errors++; $display("FAIL tag_w0: got %h want a507af99", s_dat[8'(b0 + 4)]); end
        checks++;
        if ({s_fld[8'(b0 + 7)], s_idx[8'(b0 + 7)], s_dat[8'(b0 + 7)]} !== {4'b0100, 4'd3, 32'hffa2be8c}) begin
            errors++; $display("FAIL tag_w3: got %h want ffa2be8c", s_dat[8'(b0 + 7)]); end
        checks++;
        if ({s_fld[8'(b0 + 8)], s_idx[8'(b0 + 8)], s_dat[8'(b0 + 8)]} !== {4'b0010, 4'd0, 32'h3b025e7b}) begin
            errors++; $display("FAIL c2s_w0: got %h want 3b025e7b", s_dat[8'(b0 + 8)]); end
        checks++;
        if ({s_fld[8'(b0 + 15)], s_idx[8'(b0 + 15)], s_dat[8'(b0 + 15)]} !== {4'b0010, 4'd7, 32'h873a6fc7}) begin
            errors++; $display("FAIL c2s_w7: got %h want 873a6fc7", s_dat[8'(b0 + 15)]); end
        checks++;
        if ({s_fld[8'(b0 + 16)], s_idx[8'(b0 + 16)], s_dat[8'(b0 + 16)]} !== {4'b0001, 4'd0, 32'h0ec582be}) begin
            errors++; $display("FAIL s2c_w0: got %h want 0ec582be", s_dat[8'(b0 + 16)]); end
        checks++;
        if ({s_fld[8'(b0 + 23)], s_idx[8'(b0 + 23)], s_dat[8'(b0 + 23)]} !== {4'b0001, 4'd7, 32'h6cd3c2cb}) begin
            errors++; $display("FAIL s2c_w7: got %h want 6cd3c2cb", s_dat[8'(b0 + 23)]); end
        checks++;
        if (kv_cyc + 1 !== s_cyc[8'(b0)]) begin
            errors++; $display("FAIL first_strobe_latency: got cycle %0d want %0d", s_cyc[8'(b0)], kv_cyc + 1); end
        checks++;
        if (s_cyc[8'(b0 + 23)] - s_cyc[8'(b0)] !== 23) begin
            errors++; $display("FAIL strobe_spacing: got %0d want 23", s_cyc[8'(b0 + 23)] - s_cyc[8'(b0)]); end
        checks++;
        if (n_unwrap - u0 !== 1) begin errors++; $display("FAIL valid_unwrap_count: got %0d want 1", n_unwrap - u0); end
        checks++;
        if (unwrap_cyc !== s_cyc[8'(b0 + 23)] + 1) begin
            errors++; $display("FAIL unwrap_timing: got cycle %0d want %0d", unwrap_cyc, s_cyc[8'(b0 + 23)] + 1); end
        checks++;
        if (n_err - e0 !== 0) begin errors++; $display("FAIL valid_no_error: got %0d want 0", n_err - e0); end
        checks++;
        if (n_multi !== 0) begin errors++; $display("FAIL strobe_onehot: got %0d want 0", n_multi); end
    endtask

    task automatic test_busy_unwrap();
        int b0, u0, drop;
        b0 = n_str; u0 = n_unwrap;
        send(64'h0204_0068_11223344, 1'b1, 1'b0);
        send_body(12, 11);
        busy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_unwrap - u0 !== 0) begin errors++; $display("FAIL busy_hold_unwrap: got %0d want 0", n_unwrap - u0); end
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL busy_wait_ready: got %b want 0", ifc.ready); end
        checks++;
        if (n_str - b0 !== 24) begin errors++; $display("FAIL busy_strobe_count: got %0d want 24", n_str - b0); end
        drop = cyc;
        busy = 1'b0;
        settle();
        checks++;
        if (n_unwrap - u0 !== 1) begin errors++; $display("FAIL busy_unwrap_count: got %0d want 1", n_unwrap - u0); end
        checks++;
        if (unwrap_cyc !== drop + 1) begin errors++; $display("FAIL busy_unwrap_timing: got %0d want %0d", unwrap_cyc, drop + 1); end
        busy = 1'b1; #1;
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL idle_busy_ready: got %b want 0", ifc.ready); end
        busy = 1'b0; #1;
        checks++;
        if (ifc.ready !== 1'b1) begin errors++; $display("FAIL idle_free_ready: got %b want 1", ifc.ready); end
    endtask

    task automatic test_bad_tag();
        int b0, u0, e0, k0, st0;
        b0 = n_str; u0 = n_unwrap; e0 = n_err; k0 = n_kv; st0 = stalls;
        send(64'h0205_0068_deadbeef, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) send(body[i], 1'b0, (i == 11));
        settle();
        checks++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL tag_error: got %0d want 1", n_err - e0); end
        checks++;
        if ({n_str - b0, n_unwrap - u0, n_kv - k0} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL tag_quiet: got str=%0d unwrap=%0d kv=%0d want 0", n_str - b0, n_unwrap - u0, n_kv - k0); end
        checks++;
        if (stalls - st0 !== 0) begin errors++; $display("FAIL tag_drain_ready: got %0d stalls want 0", stalls - st0); end
        busy = 1'b1; #1;
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL tag_back_idle: got %b want 0", ifc.ready); end
        busy = 1'b0; #1;
    endtask

    task automatic test_bad_len();
        int b0, e0, k0;
        b0 = n_str; e0 = n_err; k0 = n_kv;
        send(64'h0204_0060_01020304, 1'b1, 1'b0);
        settle();
        checks++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL len_error: got %0d want 1", n_err - e0); end
        checks++;
        if (key_id !== 32'h11223344) begin errors++; $display("FAIL len_key_kept: got %h want 11223344", key_id); end
        send(64'd0, 1'b0, 1'b1);
        send(64'h0204_0068_aabbccdd, 1'b1, 1'b1);
        settle();
        checks++;
        if (n_err - e0 !== 2) begin errors++; $display("FAIL first_last_error: got %0d want 2", n_err - e0); end
        checks++;
        if ({n_str - b0, n_kv - k0} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL len_quiet: got str=%0d kv=%0d want 0", n_str - b0, n_kv - k0); end
        busy = 1'b1; #1;
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL first_last_idle: got %b want 0", ifc.ready); end
        busy = 1'b0; #1;
    endtask

    task automatic test_early_last();
        int b0, u0, e0;
        b0 = n_str; u0 = n_unwrap; e0 = n_err;
        send(64'h0204_0068_55aa55aa, 1'b1, 1'b0);
        send_body(6, 5);
        settle();
        checks++;
        if (n_str - b0 !== 12) begin errors++; $display("FAIL early_strobe_count: got %0d want 12", n_str - b0); end
        checks++;
        if ({s_fld[8'(b0 + 11)], s_idx[8'(b0 + 11)], s_dat[8'(b0 + 11)]} !== {4'b0010, 4'd3, 32'hc0ffee11}) begin
            errors++; $display("FAIL early_last_strobe: got %b/%0d/%h want 0010/3/c0ffee11",
                               s_fld[8'(b0 + 11)], s_idx[8'(b0 + 11)], s_dat[8'(b0 + 11)]); end
        checks++;
        if ({n_err - e0, n_unwrap - u0} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL early_err_unwrap: got err=%0d unwrap=%0d want 1/0", n_err - e0, n_unwrap - u0); end
        b0 = n_str; u0 = n_unwrap;
        send(64'h0204_0068_6c47f0d3, 1'b1, 1'b0);
        send_body(12, 11);
        settle();
        checks++;
        if ({n_str - b0, n_unwrap - u0} !== {32'd24, 32'd1}) begin
            errors++; $display("FAIL early_recover: got str=%0d unwrap=%0d want 24/1", n_str - b0, n_unwrap - u0); end
        checks++;
        if (s_dat[8'(b0 + 23)] !== 32'h6cd3c2cb) begin
            errors++; $display("FAIL early_recover_data: got %h want 6cd3c2cb", s_dat[8'(b0 + 23)]); end
    endtask

    task automatic test_missing_last();
        int b0, u0, e0, st0;
        b0 = n_str; u0 = n_unwrap; e0 = n_err;
        send(64'h0204_0068_01010101, 1'b1, 1'b0);
        send_body(12, -1);
        settle();
        checks++;
        if ({n_str - b0, n_err - e0, n_unwrap - u0} !== {32'd24, 32'd1, 32'd0}) begin
            errors++; $display("FAIL nolast: got str=%0d err=%0d unwrap=%0d want 24/1/0",
                               n_str - b0, n_err - e0, n_unwrap - u0); end
        st0 = stalls;
        send(64'd1, 1'b0, 1'b0);
        send(64'd2, 1'b0, 1'b1);
        checks++;
        if (stalls - st0 !== 0) begin errors++; $display("FAIL nolast_drain_ready: got %0d stalls want 0", stalls - st0); end
        busy = 1'b1; #1;
        checks++;
        if (ifc.ready !== 1'b0) begin errors++; $display("FAIL nolast_idle: got %b want 0", ifc.ready); end
        busy = 1'b0; #1;
    endtask

    task automatic test_first_in_body();
        int b0, u0, e0, k0;
        b0 = n_str; u0 = n_unwrap; e0 = n_err; k0 = n_kv;
        send(64'h0204_0068_02020202, 1'b1, 1'b0);
        send_body(1, -1);
        send(64'h0204_0068_03030303, 1'b1, 1'b0);
        settle();
        checks++;
        if ({n_str - b0, n_err - e0, n_unwrap - u0, n_kv - k0} !== {32'd2, 32'd1, 32'd0, 32'd1}) begin
            errors++; $display("FAIL first_in_body: got str=%0d err=%0d unwrap=%0d kv=%0d want 2/1/0/1",
                               n_str - b0, n_err - e0, n_unwrap - u0, n_kv - k0); end
        checks++;
        if (key_id !== 32'h02020202) begin errors++; $display("FAIL first_in_body_key: got %h want 02020202", key_id); end
        send(64'd3, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int b0, u0, e0;
        send(64'h0204_0068_0f0e0d0c, 1'b1, 1'b0);
        send_body(7, -1);
        rst_n = 1'b0; #1;
        checks++;
        if ({key_id, key_vld, fld_now, c_word, c_data, unwrap, err, ifc.ready} !== 76'd0) begin
            errors++; $display("FAIL midreset_outputs: got %h want 0",
                               {key_id, key_vld, fld_now, c_word, c_data, unwrap, err, ifc.ready}); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        b0 = n_str; u0 = n_unwrap; e0 = n_err;
        @(posedge clk); #1;
        checks++;
        if (ifc.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", ifc.ready); end
        settle();
        checks++;
        if ({n_str - b0, n_unwrap - u0, n_err - e0} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL midreset_quiet: got str=%0d unwrap=%0d err=%0d want 0",
                               n_str - b0, n_unwrap - u0, n_err - e0); end
        send(64'h0204_0068_6c47f0d3, 1'b1, 1'b0);
        send_body(12, 11);
        settle();
        checks++;
        if ({n_str - b0, n_unwrap - u0, n_err - e0} !== {32'd24, 32'd1, 32'd0}) begin
            errors++; $display("FAIL midreset_recover: got str=%0d unwrap=%0d err=%0d want 24/1/0",
                               n_str - b0, n_unwrap - u0, n_err - e0); end
        checks++;
        if (key_id !== 32'h6c47f0d3) begin errors++; $display("FAIL midreset_key: got %h want 6c47f0d3", key_id); end
    endtask

    initial begin
        body[0]  = 64'hcd65766f_1a2b3c4d;
        body[1]  = 64'h5e6f7081_ca60c5ec;
        body[2]  = 64'ha507af99_13579bdf;
        body[3]  = 64'h2468ace0_ffa2be8c;
        body[4]  = 64'h3b025e7b_0badf00d;
        body[5]  = 64'hdeadbeef_c0ffee11;
        body[6]  = 64'h89abcdef_01234567;
        body[7]  = 64'hfedcba98_873a6fc7;
        body[8]  = 64'h0ec582be_11223344;
        body[9]  = 64'h55667788_99aabbcc;
        body[10] = 64'hddeeff00_a1b2c3d4;
        body[11] = 64'he5f60718_6cd3c2cb;
        test_reset();
        test_valid_cookie();
        test_busy_unwrap();
        test_bad_tag();
        test_bad_len();
        test_early_last();
        test_missing_last();
        test_first_in_body();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
